par_ser_conv_32: RTL and testbench
==================================

Name: par_ser_conv_32

Overview:
- Parallel-to-serial converter: the transmit-side counterpart of the 32-bit serial-to-parallel receiver.
- Accepts a 32-bit word through a load/ready handshake and shifts it out LSB first, one bit per clock, with a serial-valid strobe.
- A one-word holding register allows gapless back-to-back words.
- Sits between a word producer and the receiver's Data_in/En pins; its last-bit strobe lines up with the receiver's write.

Parameters:
- WIDTH, 32, word width in bits.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- Data_in  input  WIDTH  parallel word, sampled when load && ready.
- load  input  1  producer offers Data_in this cycle.
- ready  output  1  holding register empty; a word can be accepted.
- Data_out  output  1  serial data bit, LSB of the word first.
- En  output  1  Data_out carries a valid bit this cycle.
- last  output  1  high with the final bit (bit WIDTH-1) of each word.
- ovf  output  1  sticky flag: load seen while ready=0.

Behaviour:
- Reset (asynchronous, immediate, also mid-word): state=S_idle, cnt=0, shreg=0, hold=0, hold_valid=0, ovf=0.
- Output values during reset: Data_out=0, En=0, last=0, ready=1.
- Handshake:
  - ready = !hold_valid, combinational from the register.
  - load && ready captures Data_in into hold and sets hold_valid=1 at the edge.
  - load && !ready: word dropped, hold unchanged, ovf<=1. ovf is cleared only by rst.
- State S_idle:
  - If hold_valid: shreg<=hold, hold_valid<=0, cnt<=0, next state S_shift.
  - Otherwise stay in S_idle.
- State S_shift: each edge does shreg<=shreg>>1 (zero fill) and cnt<=cnt+1.
- End of word (S_shift with cnt==WIDTH-1):
  - If hold_valid: shreg<=hold, hold_valid<=0, cnt<=0, stay in S_shift (no gap bit).
  - Otherwise: next state S_idle, cnt<=0.
- Outputs are decoded from registered state only:
  - Data_out = shreg[0] when in S_shift, else 0.
  - En = (state==S_shift).
  - last = En && cnt==WIDTH-1.
- Latency: load accepted at edge k with the converter idle → first bit valid after edge k+1, last bit after edge k+WIDTH. En stays high for exactly WIDTH cycles per word.
- Simultaneous hold transfer and load:
  - ready is still 0 during the transfer cycle, so that load is dropped and ovf is set.
  - ready rises the cycle after the transfer.
- Counter wrap: cnt never wraps unguarded; it is forced to 0 at end of word.
- Throughput: with load issued whenever ready=1, the bit stream is continuous and En never drops between words.
- last aligns with the receiver: the receiver's write asserts on its 32nd bit.

Decomposition:
- Shared package holds:
  - state encoding constants S_idle=0 and S_shift=1;
  - WIDTH default 32 and CNT_W default 5;
  - the LSB-first bit-order convention, used by both converters.
- No sub-module required. Optional: factor the holding register plus ready/ovf logic as par_ser_hold_buf, reusable by other word-input blocks.

Test Plan:
- Reset mid-word: assert rst after 10 bits of a word → Data_out, En and last go to 0 immediately; ready=1, ovf=0; the next load starts a fresh word from bit 0.
- Single word: load 32'hA5A5_0001 while idle → En high for 32 cycles starting 2 edges after load.
  - Serial bits: 1, then 15 zeros, then 1,0,1,0,0,1,0,1 repeated twice (LSB first).
  - last high only on the 32nd bit; state returns to idle afterwards.
- Back-to-back: load 32'hFFFF_FFFF, then 32'h0000_0000 as soon as ready rises → 64 contiguous En cycles, 32 ones then 32 zeros; last pulses at bit 32 and bit 64.
- Overrun: load word A, then B while A shifts, then C while hold is full → C dropped, ovf=1 sticky; output is A then B only.
- Loopback: drive the serial-to-parallel receiver's Data_in/En from Data_out/En, send 32'hDEAD_BEEF and 32'h1234_5678 → receiver write coincides with last, and the receiver's Data_out equals each sent word.

Source files
------------

// File: rtl/par_ser_conv_32_pkg.sv
// Shared definitions for the 32-bit parallel/serial converter pair.
// Both directions move words LSB first.
package par_ser_conv_32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    localparam bit LSB_FIRST = 1'b1;

    typedef enum logic {
        S_idle  = 1'b0,
        S_shift = 1'b1
    } state_e;

endpackage

// File: rtl/par_ser_hold_buf.sv
// One-word holding register with ready/overflow tracking.
// A consumer empties it through take; loads while full are dropped.
module par_ser_hold_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             take,
    output logic [WIDTH-1:0] hold,
    output logic             hold_valid,
    output logic             ready,
    output logic             ovf
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;

    assign ready = !vld_q;

    always_comb begin
        hold_d = hold_q;
        vld_d  = vld_q;
        ovf_d  = ovf_q;
        // take only happens while full, so it never races an accept
        if (take) begin
            vld_d = 1'b0;
        end
        if (load && ready) begin
            hold_d = data_in;
            vld_d  = 1'b1;
        end
        if (load && !ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end

    assign hold       = hold_q;
    assign hold_valid = vld_q;
    assign ovf        = ovf_q;

endmodule

// File: rtl/par_ser_conv_32.sv
// Parallel-to-serial converter: word in via load/ready, bits out
// LSB first with En strobe and last marker on the final bit.
module par_ser_conv_32
    import par_ser_conv_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             load,
    output logic             ready,
    output logic             Data_out,
    output logic             En,
    output logic             last,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic             take;

    par_ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .data_in    (Data_in),
        .load       (load),
        .take       (take),
        .hold       (hold),
        .hold_valid (hold_valid),
        .ready      (ready),
        .ovf        (ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        take    = 1'b0;
        unique case (state_q)
            S_idle: begin
                if (hold_valid) begin
                    shreg_d = hold;
                    take    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_shift;
                end
            end
            S_shift: begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    // chain straight into the next word when one is waiting
                    cnt_d = '0;
                    if (hold_valid) begin
                        shreg_d = hold;
                        take    = 1'b1;
                    end else begin
                        state_d = S_idle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_idle;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign En       = (state_q == S_shift);
    assign Data_out = En && shreg_q[0];
    assign last     = En && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_par_ser_conv_32.sv
// Directed bench for par_ser_conv_32 with a small LSB-first
// receiver model on the serial side.
module tb_par_ser_conv_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Data_in = '0;
    logic        load = 1'b0;
    logic        ready, Data_out, En, last, ovf;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int lcyc = 0;

    bit          bits[$];
    bit          lasts[$];
    int          ecyc[$];
    logic [31:0] rx_words[$];
    bit          rx_wl[$];
    logic [31:0] rx = '0;
    int          rx_cnt = 0;

    par_ser_conv_32 dut (
        .clk      (clk),
        .rst      (rst),
        .Data_in  (Data_in),
        .load     (load),
        .ready    (ready),
        .Data_out (Data_out),
        .En       (En),
        .last     (last),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // receiver model: shifts in on En, writes on its 32nd bit
    initial forever begin
        @(negedge clk);
        if (rst) begin
            rx_cnt = 0;
        end else if (En) begin
            bits.push_back(Data_out);
            lasts.push_back(last);
            ecyc.push_back(cyc);
            rx = {Data_out, rx[31:1]};
            rx_cnt++;
            if (rx_cnt == 32) begin
                rx_words.push_back(rx);
                rx_wl.push_back(last);
                rx_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        bits.delete();
        lasts.delete();
        ecyc.delete();
        rx_words.delete();
        rx_wl.delete();
    endtask

    function automatic logic [31:0] seg(input int base, input bit sel);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) begin
            if (base + i < bits.size())
                r[i] = sel ? lasts[base+i] : bits[base+i];
        end
        return r;
    endfunction

    function automatic int span();
        if (ecyc.size() == 0) return 0;
        return ecyc[ecyc.size()-1] - ecyc[0] + 1;
    endfunction

    task automatic load_word(input logic [31:0] w, input bit wait_rdy);
        int n = 0;
        @(negedge clk);
        while (wait_rdy && !ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
        Data_in = w;
        load = 1'b1;
        @(posedge clk);
        #1;
        lcyc = cyc;
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(ready && !En) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_en", {30'd0, En, last}, 32'd0);
        chk("rst_dout_ovf", {30'd0, Data_out, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single word
        clr_mon();
        load_word(32'hA5A5_0001, 1'b1);
        chk("single_busy", 32'(ready), 32'd0);
        wait_idle();
        chk("single_cnt", 32'(bits.size()), 32'd32);
        chk("single_bits", seg(0, 1'b0), 32'hA5A5_0001);
        chk("single_last", seg(0, 1'b1), 32'h8000_0000);
        chk("single_lat", 32'(ecyc[0] - lcyc), 32'd1);
        chk("single_span", 32'(span()), 32'd32);

        // back-to-back, gapless
        clr_mon();
        load_word(32'hFFFF_FFFF, 1'b1);
        load_word(32'h0000_0000, 1'b1);
        wait_idle();
        chk("b2b_cnt", 32'(bits.size()), 32'd64);
        chk("b2b_span", 32'(span()), 32'd64);
        chk("b2b_w0", seg(0, 1'b0), 32'hFFFF_FFFF);
        chk("b2b_w1", seg(32, 1'b0), 32'h0000_0000);
        chk("b2b_l0", seg(0, 1'b1), 32'h8000_0000);
        chk("b2b_l1", seg(32, 1'b1), 32'h8000_0000);
        chk("b2b_ovf", 32'(ovf), 32'd0);

        // overrun: C dropped while hold is full
        clr_mon();
        load_word(32'h1357_9BDF, 1'b1);
        load_word(32'h2468_ACE0, 1'b1);
        load_word(32'hFFFF_0000, 1'b0);
        chk("ovr_flag", 32'(ovf), 32'd1);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("ovr_cnt", 32'(bits.size()), 32'd64);
        chk("ovr_a", seg(0, 1'b0), 32'h1357_9BDF);
        chk("ovr_b", seg(32, 1'b0), 32'h2468_ACE0);
        chk("ovr_sticky", 32'(ovf), 32'd1);

        // async reset mid-word
        clr_mon();
        load_word(32'hCAFE_F00D, 1'b1);
        for (int n = 0; n < 100 && bits.size() < 10; n++)
            @(negedge clk);
        chk("mid_ten_bits", 32'(bits.size()), 32'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {29'd0, Data_out, En, last}, 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clr_mon();
        load_word(32'h0000_0003, 1'b1);
        wait_idle();
        chk("mid_fresh_cnt", 32'(bits.size()), 32'd32);
        chk("mid_fresh_bits", seg(0, 1'b0), 32'h0000_0003);

        // load on the transfer edge is dropped
        clr_mon();
        load_word(32'h8000_0001, 1'b1);
        load_word(32'h7777_7777, 1'b0);
        chk("xfer_ready", 32'(ready), 32'd1);
        chk("xfer_ovf", 32'(ovf), 32'd1);
        wait_idle();
        chk("xfer_cnt", 32'(bits.size()), 32'd32);
        chk("xfer_bits", seg(0, 1'b0), 32'h8000_0001);

        // loopback into receiver model
        clr_mon();
        load_word(32'hDEAD_BEEF, 1'b1);
        load_word(32'h1234_5678, 1'b1);
        wait_idle();
        chk("loop_words", 32'(rx_words.size()), 32'd2);
        chk("loop_w0", rx_words[0], 32'hDEAD_BEEF);
        chk("loop_w1", rx_words[1], 32'h1234_5678);
        chk("loop_wl", {30'd0, rx_wl[0], rx_wl[1]}, 32'd3);
        chk("loop_span", 32'(span()), 32'd64);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
